// File: rtl/vec_unload.sv
// -----------------------------------------------------------------------------
// vec_unload
//
// Purpose:
//   Unloads one entry of a vector cache as a stream of single elements. A start
//   request latches the entry address. One capture cycle copies the whole
//   vector into a local buffer, so later cache writes cannot disturb the
//   transfer. The buffer is then streamed element by element over a
//   valid/ready handshake. The transfer ends with a one-cycle done pulse.
//
//   Elements are carried as IEEE-754 single-precision bit patterns (32 bits),
//   which is the hardware form of a shortreal.
//
// Ports:
//   clock            - single clock, rising edge
//   reset            - synchronous active-high reset
//   start            - request to unload one cache entry (ignored unless idle)
//   start_addr       - cache entry to unload, sampled with start
//   start_count      - element count, sampled with start (optional, see below)
//   cache_read_addr  - read address to the vector cache (holds last latched)
//   cache_data       - combinational cache read data, WIDTH elements
//   out_valid        - an element is presented
//   out_ready        - consumer accepts the presented element
//   out_data         - presented element
//   out_index        - element index of out_data
//   out_last         - presented element is the final one of the transfer
//   busy             - high in every state except IDLE
//   done             - one-cycle completion pulse
//
// Configuration:
//   VEC_UNLOAD_COUNT_EN - when defined, adds the start_count input. Its value
//   becomes the transfer length, clamped to WIDTH. A length of 0 goes straight
//   from CAPTURE to DONE. When undefined, the length is always WIDTH.
// -----------------------------------------------------------------------------
module vec_unload #(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
  parameter int CACHE_SIZE      = 4,
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CACHE_ADDR_SIZE-1:0] start_addr,
`ifdef VEC_UNLOAD_COUNT_EN
  input  logic [WIDTH_ADDR_SIZE:0]   start_count,
`endif
  output logic [CACHE_ADDR_SIZE-1:0] cache_read_addr,
  input  logic [31:0]                cache_data [WIDTH],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_data,
  output logic [WIDTH_ADDR_SIZE-1:0] out_index,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_STREAM  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [WIDTH_ADDR_SIZE:0] LEN_FULL = (WIDTH_ADDR_SIZE+1)'(WIDTH);

  logic [1:0]                 r_state;
  logic [CACHE_ADDR_SIZE-1:0] r_addr;
  logic [WIDTH_ADDR_SIZE-1:0] r_index;
  logic [31:0]                r_buf [WIDTH];

  logic [WIDTH_ADDR_SIZE:0]   w_len;
  logic                       w_last;
  logic                       w_hs;

`ifdef VEC_UNLOAD_COUNT_EN
  logic [WIDTH_ADDR_SIZE:0]   r_len;
  logic [WIDTH_ADDR_SIZE:0]   w_count_clamped;

  assign w_count_clamped = (start_count > LEN_FULL) ? LEN_FULL : start_count;
  assign w_len           = r_len;
`else
  assign w_len           = LEN_FULL;
`endif

  // Index is one bit narrower than the length, so widen it before comparing.
  assign w_last = (r_state == S_STREAM) && ({1'b0, r_index} == (w_len - 1'b1));
  assign w_hs   = (r_state == S_STREAM) && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_index <= '0;
`ifdef VEC_UNLOAD_COUNT_EN
      r_len   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= start_addr;
`ifdef VEC_UNLOAD_COUNT_EN
            r_len   <= w_count_clamped;
`endif
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_index <= '0;
          r_state <= (w_len == '0) ? S_DONE : S_STREAM;
        end
        S_STREAM: begin
          // The last element leaves the index parked at length-1 (no wrap).
          if (w_hs) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Snapshot of the whole vector. No reset: contents only matter after a capture.
  always_ff @(posedge clock) begin
    if (r_state == S_CAPTURE) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_buf[i] <= cache_data[i];
      end
    end
  end

  // The latched address doubles as the cache read address in every state.
  assign cache_read_addr = r_addr;
  assign out_valid       = (r_state == S_STREAM);
  assign out_data        = r_buf[r_index];
  assign out_index       = r_index;
  assign out_last        = w_last;
  assign busy            = (r_state != S_IDLE);
  assign done            = (r_state == S_DONE);

endmodule

// File: tb/tb_vec_unload.sv
module tb_vec_unload;

  localparam int WIDTH = 128;
  localparam int WAS   = $clog2(WIDTH);
  localparam int CS    = 4;
  localparam int CAS   = $clog2(CS);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset;
  logic             start;
  logic [CAS-1:0]   start_addr;
`ifdef VEC_UNLOAD_COUNT_EN
  logic [WAS:0]     start_count;
`endif
  logic [CAS-1:0]   cache_read_addr;
  logic [31:0]      cache_data [WIDTH];
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [WAS-1:0]   out_index;
  logic             out_last;
  logic             busy;
  logic             done;

  // Behavioural cache: combinational read of the addressed entry.
  logic [31:0] cache_mem [CS][WIDTH];
  always_comb begin
    for (int i = 0; i < WIDTH; i++) cache_data[i] = cache_mem[cache_read_addr][i];
  end

  vec_unload #(
    .WIDTH(WIDTH), .WIDTH_ADDR_SIZE(WAS), .CACHE_SIZE(CS), .CACHE_ADDR_SIZE(CAS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
`ifdef VEC_UNLOAD_COUNT_EN
    .start_count(start_count),
`endif
    .cache_read_addr(cache_read_addr),
    .cache_data(cache_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_index(out_index),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  int errors = 0;
  int checks = 0;
  int obs_hs;
  int obs_done;

  typedef struct {
    int addr;
    int cnt;
    int rmode;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    bit corrupt; // zero the entry right after capture
    bit hold;    // keep start high through the transfer
    int exp_n;   // expected handshakes (-1: unchecked)
    int exp_done;// expected done cycle relative to start (-1: unchecked)
  } vec_t;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Single-precision bit pattern of i + 0.5, built from the float format rules.
  function automatic logic [31:0] half_bits(input int i);
    int n;
    int e;
    n = 2 * i + 1;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(126 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  task automatic observe(input int cyc);
    if (out_valid && out_ready) obs_hs++;
    if (done && obs_done < 0) obs_done = cyc;
  endtask

  task automatic fill_random();
    for (int a = 0; a < CS; a++)
      for (int i = 0; i < WIDTH; i++) cache_mem[a][i] = $urandom;
  endtask

  // One transfer, checked cycle by cycle against an ordered-list model:
  // the captured vector is presented in order, one element held until accepted.
  task automatic run_xfer(input int addr, input int cnt, input int rmode,
                          input bit corrupt, input bit hold);
    int len;
    int k;
    int cyc;
    bit rdy;
    logic [31:0] snap [WIDTH];
    len = WIDTH;
`ifdef VEC_UNLOAD_COUNT_EN
    len = (cnt > WIDTH) ? WIDTH : cnt;
    start_count = (WAS+1)'(cnt);
`endif
    obs_hs = 0;
    obs_done = -1;
    start = 1'b1;
    start_addr = CAS'(addr);
    out_ready = 1'b0;
    observe(0);
    tick();
    cyc = 1;
    if (!hold) start = 1'b0;
    chk("capture_rd_addr", 32'(cache_read_addr), addr);
    chk("capture_busy", 32'(busy), 1);
    chk("capture_valid", 32'(out_valid), 0);
    observe(cyc);
    for (int i = 0; i < WIDTH; i++) snap[i] = cache_mem[addr][i];
    tick();
    cyc = 2;
    if (corrupt) for (int i = 0; i < WIDTH; i++) cache_mem[addr][i] = '0;
    k = 0;
    while (k < len) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (((cyc - 2) % 4) == 0) || (((cyc - 2) % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_index", 32'(out_index), k);
      chk("stream_data", out_data, snap[k]);
      chk("stream_last", 32'(out_last), (k == len - 1) ? 1 : 0);
      observe(cyc);
      if (rdy) k++;
      tick();
      cyc++;
    end
    out_ready = 1'($urandom_range(0, 1));
    chk("done_pulse", 32'(done), 1);
    chk("done_valid", 32'(out_valid), 0);
    chk("done_last", 32'(out_last), 0);
    chk("done_busy", 32'(busy), 1);
    observe(cyc);
    tick();
    cyc++;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_valid", 32'(out_valid), 0);
    chk("hold_rd_addr", 32'(cache_read_addr), addr);
    observe(cyc);
  endtask

  initial begin
    vec_t vecs[$];
    int len;
    int cnt;

    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    out_ready = 1'b0;
`ifdef VEC_UNLOAD_COUNT_EN
    start_count = '0;
`endif
    fill_random();
    tick();
    start = 1'b1;  // reset must win over start
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_addr", 32'(cache_read_addr), 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    vecs.push_back('{2, WIDTH, 0, 1'b0, 1'b0, 128, 130}); // full-rate transfer
    vecs.push_back('{2, WIDTH, 1, 1'b0, 1'b0, 128, 258}); // 1,0,0,1 ready
    vecs.push_back('{2, WIDTH, 0, 1'b1, 1'b0, 128, 130}); // overwrite after capture
    vecs.push_back('{1, WIDTH, 0, 1'b0, 1'b1, 128, 130}); // start held throughout
    vecs.push_back('{1, WIDTH, 0, 1'b0, 1'b0, 128, 130}); // restart from the IDLE cycle
    vecs.push_back('{3, WIDTH, 2, 1'b0, 1'b0, 128, -1});  // random ready
`ifdef VEC_UNLOAD_COUNT_EN
    vecs.push_back('{2, 3,   0, 1'b0, 1'b0, 3,   5});
    vecs.push_back('{2, 0,   0, 1'b0, 1'b0, 0,   2});
    vecs.push_back('{2, 200, 0, 1'b0, 1'b0, 128, 130});
    vecs.push_back('{0, 129, 1, 1'b0, 1'b0, 128, 258});
`endif

    foreach (vecs[v]) begin
      for (int a = 0; a < CS; a++)
        for (int i = 0; i < WIDTH; i++)
          cache_mem[a][i] = (a == 2) ? half_bits(i) : $urandom;
      run_xfer(vecs[v].addr, vecs[v].cnt, vecs[v].rmode, vecs[v].corrupt, vecs[v].hold);
      if (vecs[v].exp_n >= 0) chk("vec_elements", obs_hs, vecs[v].exp_n);
      if (vecs[v].exp_done >= 0) chk("vec_done_cycle", obs_done, vecs[v].exp_done);
      $display("vector %0d addr=%0d cnt=%0d rmode=%0d: elements=%0d done_cycle=%0d",
               v, vecs[v].addr, vecs[v].cnt, vecs[v].rmode, obs_hs, obs_done);
    end
    start = 1'b0;

    // Randomized transfers against the ordered-list model.
    for (int r = 0; r < 6; r++) begin
      int addr;
      fill_random();
      addr = $urandom_range(0, CS - 1);
      cnt = WIDTH;
`ifdef VEC_UNLOAD_COUNT_EN
      cnt = $urandom_range(0, 255);
`endif
      len = (cnt > WIDTH) ? WIDTH : cnt;
      run_xfer(addr, cnt, 2, 1'($urandom_range(0, 1)), 1'b0);
      chk("rand_elements", obs_hs, len);
      $display("random %0d addr=%0d cnt=%0d: elements=%0d done_cycle=%0d",
               r, addr, cnt, obs_hs, obs_done);
    end

    // Reset in the middle of a stream, then a clean restart.
    for (int i = 0; i < WIDTH; i++) cache_mem[3][i] = half_bits(i);
    start = 1'b1;
    start_addr = 2'd3;
`ifdef VEC_UNLOAD_COUNT_EN
    start_count = (WAS+1)'(WIDTH);
`endif
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (40) tick();
    chk("mid_index", 32'(out_index), 40);
    chk("mid_data", out_data, half_bits(40));
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_rd_addr", 32'(cache_read_addr), 0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("after_rst_busy", 32'(busy), 0);
    $display("reset at element 40: valid=%0d busy=%0d done=%0d", out_valid, busy, done);
    run_xfer(3, WIDTH, 0, 1'b0, 1'b0);
    chk("restart_elements", obs_hs, WIDTH);
    chk("restart_done_cycle", obs_done, WIDTH + 2);
    $display("restart after reset: elements=%0d done_cycle=%0d", obs_hs, obs_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
